// File: rtl/key_step_conditioner.sv
// key_step_conditioner: pushbutton front end for the multicycle processor.
// Each raw KEY is synchronised and debounced by its own FSM. KEY[1] becomes a
// one-cycle step enable and KEY[0] becomes a stretched processor reset. A
// 16-bit step counter feeds the debug displays.
// Optional feature macro: AUTO_STEP_EN (auto-repeat stepping while KEY[1] is held).
module key_step_conditioner #(
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int CNT_W            = 20,
   parameter int RST_STRETCH      = 4,
   parameter int KEY_ACTIVE_LOW   = 1
`ifdef AUTO_STEP_EN
   ,
   parameter int AUTO_HOLD_CYCLES = 64,
   parameter int AUTO_PERIOD      = 8
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  key_in,
   output logic        step_pulse,
   output logic        proc_reset,
   output logic [1:0]  key_state,
   output logic [15:0] step_count
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_st_t;

   localparam int SW = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);
   localparam logic [SW-1:0]    STRETCH_INIT = SW'(RST_STRETCH);
   localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Raw pin level when nothing is pressed
   localparam logic [1:0]       KEY_IDLE     = (KEY_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       key_sync;
   key_st_t          state_q [2];
   key_st_t          state_d [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       key_state_q, key_state_d;
   logic [1:0]       enter_pressed;
   logic [SW-1:0]    stretch_q, stretch_d;
   logic             proc_reset_q, proc_reset_d;
   logic             step_pulse_q, step_pulse_d;
   logic [15:0]      step_count_q, step_count_d;
   logic             rst_gate;
   logic             auto_fire;

`ifdef AUTO_STEP_EN
   localparam int HW = $clog2(AUTO_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(AUTO_HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_REARM  = HW'(AUTO_HOLD_CYCLES - AUTO_PERIOD);
   logic [HW-1:0] hold_q, hold_d;
`endif

   // Polarity normalisation: key_sync is 1 while a button is pressed
   assign key_sync = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   // Per-key debounce FSMs with their counters
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         state_d[k]       = state_q[k];
         cnt_d[k]         = cnt_q[k];
         key_state_d[k]   = key_state_q[k];
         enter_pressed[k] = 1'b0;
         case (state_q[k])
            IDLE: begin
               if (key_sync[k]) begin
                  state_d[k] = PRESS_WAIT;
                  cnt_d[k]   = {CNT_W{1'b0}};
               end else begin
                  state_d[k] = IDLE;
               end
            end
            PRESS_WAIT: begin
               if (!key_sync[k]) begin
                  state_d[k] = IDLE;
               end else if (cnt_q[k] == DB_LAST) begin
                  state_d[k]       = PRESSED;
                  key_state_d[k]   = 1'b1;
                  enter_pressed[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!key_sync[k]) begin
                  state_d[k] = RELEASE_WAIT;
                  cnt_d[k]   = {CNT_W{1'b0}};
               end else begin
                  state_d[k] = PRESSED;
               end
            end
            RELEASE_WAIT: begin
               if (key_sync[k]) begin
                  state_d[k] = PRESSED;
               end else if (cnt_q[k] == DB_LAST) begin
                  state_d[k]     = IDLE;
                  key_state_d[k] = 1'b0;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            default: begin
               state_d[k]     = IDLE;
               cnt_d[k]       = {CNT_W{1'b0}};
               key_state_d[k] = 1'b0;
            end
         endcase
      end
   end

`ifdef AUTO_STEP_EN
   // Auto-repeat: hold counter runs in PRESSED, freezes otherwise, clears in IDLE
   always_comb begin
      hold_d    = hold_q;
      auto_fire = 1'b0;
      if (state_q[1] == IDLE) begin
         hold_d = {HW{1'b0}};
      end else if ((state_q[1] == PRESSED) && key_sync[1]) begin
         if (hold_q == HOLD_LAST) begin
            auto_fire = 1'b1;
            hold_d    = HOLD_REARM;
         end else begin
            hold_d = hold_q + HW'(1);
         end
      end else begin
         hold_d = hold_q;
      end
   end
`else
   assign auto_fire = 1'b0;
`endif

   // Reset stretcher, step enable and step counter
   always_comb begin
      // Reload on the debounced edge itself so proc_reset rises with key_state[0],
      // and keep reloading while it is held so the fall comes RST_STRETCH edges later
      if (key_state_d[0] || key_state_q[0]) begin
         stretch_d = STRETCH_INIT;
      end else if (stretch_q != {SW{1'b0}}) begin
         stretch_d = stretch_q - SW'(1);
      end else begin
         stretch_d = {SW{1'b0}};
      end
      proc_reset_d = key_state_d[0] | key_state_q[0] | (stretch_d != {SW{1'b0}});
      // A reset that is active now or starting this cycle swallows any step
      rst_gate     = proc_reset_q | proc_reset_d;
      step_pulse_d = (enter_pressed[1] | auto_fire) & ~rst_gate;
      if (rst_gate) begin
         step_count_d = 16'd0;
      end else if (step_pulse_d) begin
         step_count_d = step_count_q + 16'd1;
      end else begin
         step_count_d = step_count_q;
      end
   end

   // State registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q      <= KEY_IDLE;
         sync2_q      <= KEY_IDLE;
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= {CNT_W{1'b0}};
         end
         key_state_q  <= 2'b00;
         stretch_q    <= STRETCH_INIT;
         proc_reset_q <= 1'b1;
         step_pulse_q <= 1'b0;
         step_count_q <= 16'd0;
`ifdef AUTO_STEP_EN
         hold_q       <= {HW{1'b0}};
`endif
      end else begin
         sync1_q      <= key_in;
         sync2_q      <= sync1_q;
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         key_state_q  <= key_state_d;
         stretch_q    <= stretch_d;
         proc_reset_q <= proc_reset_d;
         step_pulse_q <= step_pulse_d;
         step_count_q <= step_count_d;
`ifdef AUTO_STEP_EN
         hold_q       <= hold_d;
`endif
      end
   end

   assign step_pulse = step_pulse_q;
   assign proc_reset = proc_reset_q;
   assign key_state  = key_state_q;
   assign step_count = step_count_q;

endmodule
